handshake_responder: RTL
========================

Name: handshake_responder

Overview:
- Receive-side handshake generator for the USB link layer; the responder counterpart to the link controller's "send data, await handshake" path.
- On end of a received DATA packet it checks CRC16, the DATA0/DATA1 toggle, buffer readiness and stall.
- It waits the turnaround delay, then requests transmission of ACK, NAK or STALL from the TX path.
- It tells the data buffer whether to commit or discard the packet just received.

Parameters:
- DLY_W, 6, width of delay_threshold and of the turnaround counter.
- TO_W, 8, width of the handshake timeout counter.
- HS_TIMEOUT, 8'd200, cycles allowed in REQ+SEND before abort.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- rx_sop_en  input  1  pulse; start of DATA packet reception.
- rx_lt_eop_en  input  1  pulse; end of DATA packet reception.
- rx_data_pid  input  4  PID of the received packet; valid with rx_lt_eop_en.
- crc16_err  input  1  CRC16 result; valid with rx_lt_eop_en.
- buf_ready  input  1  level; receive buffer can accept a packet.
- stall  input  1  level; endpoint halted.
- toggle_clr  input  1  pulse; force expected toggle to DATA0.
- delay_threshold  input  DLY_W  turnaround delay setting.
- tx_hs_ready  input  1  TX path can accept a handshake request.
- tx_lp_eop_en  input  1  pulse; TX packet finished.
- tx_hs_req  output  1  handshake transmit request (level).
- tx_hs_pid  output  4  PID to send: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
- data_commit  output  1  pulse; keep received data.
- data_discard  output  1  pulse; drop received data.
- exp_toggle  output  1  expected data toggle (0 = DATA0 4'b0011, 1 = DATA1 4'b1011).
- hs_busy  output  1  high in any state other than IDLE.
- hs_abort  output  1  pulse; handshake timed out.

Behaviour:
- Reset (rst high at clk edge) applies the following; reset mid-operation drops any pending handshake with no commit/discard pulse:
  - state = IDLE.
  - All outputs 0; tx_hs_pid = 4'b0000; exp_toggle = 0.
  - Both counters 0.
- States: IDLE, RX, TAT, REQ, SEND.
- IDLE -> RX on rx_sop_en. rx_lt_eop_en seen in IDLE is ignored. rx_sop_en seen in RX is ignored (stay in RX). rx_sop_en seen in TAT/REQ/SEND is ignored.
- RX, on rx_lt_eop_en, decide by priority; the outputs listed are registered and take effect the next cycle:
  1. crc16_err=1, or PID not DATA0/DATA1: data_discard pulse; -> IDLE; no handshake.
  2. stall=1: tx_hs_pid = STALL; discard; -> TAT.
  3. buf_ready=0: tx_hs_pid = NAK; discard; -> TAT.
  4. PID toggle != exp_toggle (retransmission): tx_hs_pid = ACK; discard; -> TAT; toggle unchanged.
  5. Otherwise: tx_hs_pid = ACK; data_commit pulse; exp_toggle flips; -> TAT.
- Commit/discard are single-cycle pulses, mutually exclusive, exactly one per accepted end-of-packet.
- TAT: counter starts at 0 on entry and increments each cycle. When counter == delay_threshold -> REQ, counter cleared. TAT therefore lasts delay_threshold+1 cycles; threshold 0 gives one TAT cycle.
- REQ: tx_hs_req=1 and tx_hs_pid held stable. At the first edge with tx_hs_ready=1 -> SEND; tx_hs_req drops that same edge.
- SEND: tx_hs_req=0; on tx_lp_eop_en -> IDLE. tx_hs_pid holds its value until the next decision.
- Timeout:
  - Counter runs in REQ and SEND and clears on entering REQ.
  - If it reaches HS_TIMEOUT: one-cycle hs_abort pulse; -> IDLE; tx_hs_req=0.
  - tx_lp_eop_en in the same cycle as the timeout: the normal exit wins, no abort.
- toggle_clr sets exp_toggle=0 in any state. It has priority over a flip in the same cycle.
- Inputs are sampled only in the states above; tx_lp_eop_en outside SEND is ignored.
- hs_busy = (state != IDLE), registered.

Test Plan:
- Good packet: exp_toggle=0, buf_ready=1, DATA0 PID 4'b0011, crc ok, delay_threshold=3 -> data_commit one cycle after eop; exp_toggle=1; tx_hs_req rises 5 cycles after eop with pid 4'b0010; tx_hs_ready=1 -> SEND; tx_lp_eop_en -> IDLE, hs_busy=0.
- Retransmission: exp_toggle=1, DATA0 received -> ACK 4'b0010 sent; data_discard pulse; exp_toggle stays 1.
- NAK and STALL:
  - buf_ready=0 -> pid 4'b1010, discard.
  - stall=1 with buf_ready=0 -> pid 4'b1110 (stall wins), discard.
  - exp_toggle unchanged in both cases.
- CRC error: crc16_err=1 at eop -> discard pulse; no tx_hs_req ever; IDLE next cycle.
- Timeout: tx_hs_ready held 0 -> hs_abort after 200 cycles in REQ; tx_hs_req=0; IDLE. Repeat with tx_lp_eop_en on cycle 200 -> no abort.
- Corner cases:
  - toggle_clr in the same cycle as a commit flip -> exp_toggle=0.
  - rst asserted in TAT -> all outputs 0 next cycle, no request issued.
  - delay_threshold=0 -> tx_hs_req 2 cycles after eop.

Source files
------------

// File: rtl/handshake_responder.sv
// Receive-side USB handshake responder: judges a received DATA packet, waits the
// bus turnaround, requests ACK/NAK/STALL from the TX path and commits or drops the data.
module handshake_responder #(
  parameter int unsigned     DLY_W      = 6,
  parameter int unsigned     TO_W       = 8,
  parameter logic [TO_W-1:0] HS_TIMEOUT = 8'd200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_sop_en,
  input  logic             rx_lt_eop_en,
  input  logic [3:0]       rx_data_pid,
  input  logic             crc16_err,
  input  logic             buf_ready,
  input  logic             stall,
  input  logic             toggle_clr,
  input  logic [DLY_W-1:0] delay_threshold,
  input  logic             tx_hs_ready,
  input  logic             tx_lp_eop_en,
  output logic             tx_hs_req,
  output logic [3:0]       tx_hs_pid,
  output logic             data_commit,
  output logic             data_discard,
  output logic             exp_toggle,
  output logic             hs_busy,
  output logic             hs_abort
);

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [TO_W-1:0] TO_LAST = HS_TIMEOUT - TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RX   = 3'd1,
    S_TAT  = 3'd2,
    S_REQ  = 3'd3,
    S_SEND = 3'd4
  } state_t;

  state_t           state_q;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] dly_d;
  logic [TO_W-1:0]  to_q;
  logic [TO_W-1:0]  to_d;

  // DATA0 and DATA1 differ only in bit 3, which is the toggle bit.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid[2:0] == 3'b011);
  endfunction

  // Counter increments shared by the turnaround and timeout paths.
  always_comb begin
    dly_d = dly_q + DLY_W'(1);
    to_d  = to_q + TO_W'(1);
  end

  // Handshake FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dly_q        <= '0;
      to_q         <= '0;
      tx_hs_req    <= 1'b0;
      tx_hs_pid    <= 4'b0000;
      data_commit  <= 1'b0;
      data_discard <= 1'b0;
      exp_toggle   <= 1'b0;
      hs_busy      <= 1'b0;
      hs_abort     <= 1'b0;
    end else begin
      data_commit  <= 1'b0;
      data_discard <= 1'b0;
      hs_abort     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_sop_en) begin
            state_q <= S_RX;
            hs_busy <= 1'b1;
          end
        end
        S_RX: begin
          if (rx_lt_eop_en) begin
            if (crc16_err || !is_data_pid(rx_data_pid)) begin
              data_discard <= 1'b1;
              state_q      <= S_IDLE;
              hs_busy      <= 1'b0;
            end else begin
              state_q <= S_TAT;
              dly_q   <= '0;
              if (stall) begin
                tx_hs_pid    <= PID_STALL;
                data_discard <= 1'b1;
              end else if (!buf_ready) begin
                tx_hs_pid    <= PID_NAK;
                data_discard <= 1'b1;
              end else if (rx_data_pid[3] != exp_toggle) begin
                tx_hs_pid    <= PID_ACK;
                data_discard <= 1'b1;
              end else begin
                tx_hs_pid   <= PID_ACK;
                data_commit <= 1'b1;
                exp_toggle  <= ~exp_toggle;
              end
            end
          end
        end
        S_TAT: begin
          if (dly_q == delay_threshold) begin
            state_q   <= S_REQ;
            dly_q     <= '0;
            to_q      <= '0;
            tx_hs_req <= 1'b1;
          end else begin
            dly_q <= dly_d;
          end
        end
        S_REQ: begin
          if (tx_hs_ready) begin
            state_q   <= S_SEND;
            tx_hs_req <= 1'b0;
            to_q      <= to_d;
          end else if (to_q >= TO_LAST) begin
            state_q   <= S_IDLE;
            tx_hs_req <= 1'b0;
            hs_abort  <= 1'b1;
            hs_busy   <= 1'b0;
            to_q      <= '0;
          end else begin
            to_q <= to_d;
          end
        end
        S_SEND: begin
          // A normal end of transmission beats a coincident timeout.
          if (tx_lp_eop_en) begin
            state_q <= S_IDLE;
            hs_busy <= 1'b0;
            to_q    <= '0;
          end else if (to_q >= TO_LAST) begin
            state_q  <= S_IDLE;
            hs_abort <= 1'b1;
            hs_busy  <= 1'b0;
            to_q     <= '0;
          end else begin
            to_q <= to_d;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          tx_hs_req <= 1'b0;
          hs_busy   <= 1'b0;
          dly_q     <= '0;
          to_q      <= '0;
        end
      endcase
      if (toggle_clr) begin
        exp_toggle <= 1'b0;
      end
    end
  end

endmodule
